// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants, the CIC register-width helper and the PCM sample
// type for the PDM receive path. There are no ports.
`timescale 1ns/1ps
package pdm_pkg;

   localparam int PDM_CLK_DIV = 71;   // clk cycles per PDM bit clock period
   localparam int PDM_DECIM   = 32;   // PDM bits per PCM sample
   localparam int CIC_ORDER   = 3;    // integrator/comb pairs

   typedef logic signed [15:0] pcm_sample_t;

   // A CIC of order N, decimation R and differential delay 1 grows by
   // N*log2(R) bits. The base of 2 bits holds the +/-1 input, and its sign,
   // without overflow. An example is 17 bits at R=32.
   function automatic int cic_width(input int decim);
      return 2 + CIC_ORDER * $clog2(decim);
   endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: bit-clock divider and input capture for the PDM receiver.
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   enable   in   run; low holds the divider at 0 and pdm_clk low
//   pdm_data in   asynchronous PDM bit from the microphone
//   pdm_clk  out  registered PDM bit clock: high for div_cnt < CLK_DIV/2
//   cap_stb  out  one-cycle strobe: capture cap_bit now
//   cap_bit  out  synchronized PDM bit
`timescale 1ns/1ps
module pdm_clk_gen
   import pdm_pkg::*;
#(
   parameter int CLK_DIV = PDM_CLK_DIV,
   parameter bit EDGE    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic pdm_data,
   output logic pdm_clk,
   output logic cap_stb,
   output logic cap_bit
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2);
   // Sample just before the edge on which the mic stops driving.
   // EDGE=0: the last count before pdm_clk rises.
   // EDGE=1: the last count before pdm_clk falls.
   localparam logic [CNT_W-1:0] CAP_CNT  = EDGE ? CNT_W'(CLK_DIV / 2 - 1) : LAST_CNT;

   logic [CNT_W-1:0] div_cnt_reg;
   logic [CNT_W-1:0] div_cnt_next;
   logic             pdm_clk_reg;
   logic [1:0]       sync_reg;

   always_comb begin
      div_cnt_next = '0;
      if (enable && (div_cnt_reg != LAST_CNT))
         div_cnt_next = div_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_reg <= '0;
         pdm_clk_reg <= 1'b0;
         sync_reg    <= '0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         // pdm_clk is decoded from the next count, so the flop lines up
         // with div_cnt_reg. It carries no extra cycle of lag.
         pdm_clk_reg <= enable && (div_cnt_next < HALF_CNT);
         sync_reg    <= {sync_reg[0], pdm_data};
      end
   end

   assign pdm_clk = pdm_clk_reg;
   assign cap_stb = enable && (div_cnt_reg == CAP_CNT);
   assign cap_bit = sync_reg[1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM microphone receiver. A 3rd-order CIC decimates the
// 1-bit stream to signed 16-bit PCM at one sample per CLK_DIV*DECIM clk cycles.
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   enable       in   run; low = idle, pipeline cleared
//   pdm_clk      out  PDM bit clock to the microphone
//   pdm_data     in   asynchronous PDM stream (1 = +1, 0 = -1)
//   sample_out   out  signed PCM sample, valid while sample_valid
//   sample_valid out  held until accepted
//   sample_ready in   consumer accepts when sample_valid && sample_ready
//   overrun      out  one-cycle pulse when an unaccepted sample is replaced
`timescale 1ns/1ps
module pdm_cic_decimator
   import pdm_pkg::*;
#(
   parameter int CLK_DIV = PDM_CLK_DIV,
   parameter int DECIM   = PDM_DECIM,
   parameter bit EDGE    = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   output logic               pdm_clk,
   input  logic               pdm_data,
   output logic signed [15:0] sample_out,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic               overrun
);

   localparam int W     = cic_width(DECIM);
   localparam int BIT_W = $clog2(DECIM);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DECIM - 1);
   localparam logic [1:0] WARM_FRAMES = 2'd3;

   typedef logic signed [W-1:0] acc_t;

   logic cap_stb;
   logic cap_bit;

   pdm_clk_gen #(
      .CLK_DIV (CLK_DIV),
      .EDGE    (EDGE)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .pdm_data (pdm_data),
      .pdm_clk  (pdm_clk),
      .cap_stb  (cap_stb),
      .cap_bit  (cap_bit)
   );

   acc_t             integ_reg  [CIC_ORDER];
   acc_t             integ_next [CIC_ORDER];
   acc_t             dly_reg    [CIC_ORDER];
   acc_t             comb_in    [CIC_ORDER];
   acc_t             comb_out   [CIC_ORDER];
   acc_t             x_val;
   logic [BIT_W-1:0] bit_cnt_reg;
   logic             dec_stb_reg;
   logic [1:0]       warm_cnt_reg;
   pcm_sample_t      sample_reg;
   logic             valid_reg;
   logic             overrun_reg;
   pcm_sample_t      sat_val;
   logic             load;

   assign x_val = cap_bit ? acc_t'(1) : acc_t'(-1);

   // The integrator chain is combinational within one capture. Each
   // integrator sees the new value of the one before it, so that the
   // decimated output covers exactly the most recent bits, including the
   // last bit of the frame. The comb chain likewise differences against
   // the previous decimated value.
   always_comb begin
      integ_next[0] = integ_reg[0] + x_val;
      for (int i = 1; i < CIC_ORDER; i++)
         integ_next[i] = integ_reg[i] + integ_next[i-1];
      comb_in[0]  = integ_reg[CIC_ORDER-1];
      comb_out[0] = comb_in[0] - dly_reg[0];
      for (int i = 1; i < CIC_ORDER; i++) begin
         comb_in[i]  = comb_out[i-1];
         comb_out[i] = comb_in[i] - dly_reg[i];
      end
   end

   // The only out-of-range value is +DECIM^3 (all ones), which clips to +max.
   // Narrow filters (small DECIM) just sign-extend.
   generate
      if (W > 16) begin : g_sat
         localparam acc_t PCM_MAX = acc_t'(32767);
         localparam acc_t PCM_MIN = acc_t'(-32768);
         always_comb begin
            sat_val = comb_out[CIC_ORDER-1][15:0];
            if (comb_out[CIC_ORDER-1] > PCM_MAX)
               sat_val = 16'sh7FFF;
            else if (comb_out[CIC_ORDER-1] < PCM_MIN)
               sat_val = 16'sh8000;
         end
      end else begin : g_ext
         assign sat_val = pcm_sample_t'(comb_out[CIC_ORDER-1]);
      end
   endgenerate

   assign load = dec_stb_reg && (warm_cnt_reg == WARM_FRAMES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CIC_ORDER; i++) begin
            integ_reg[i] <= '0;
            dly_reg[i]   <= '0;
         end
         bit_cnt_reg  <= '0;
         dec_stb_reg  <= 1'b0;
         warm_cnt_reg <= '0;
         sample_reg   <= '0;
         valid_reg    <= 1'b0;
         overrun_reg  <= 1'b0;
      end else if (!enable) begin
         for (int i = 0; i < CIC_ORDER; i++) begin
            integ_reg[i] <= '0;
            dly_reg[i]   <= '0;
         end
         bit_cnt_reg  <= '0;
         dec_stb_reg  <= 1'b0;
         warm_cnt_reg <= '0;
         sample_reg   <= '0;
         valid_reg    <= 1'b0;
         overrun_reg  <= 1'b0;
      end else begin
         if (cap_stb) begin
            for (int i = 0; i < CIC_ORDER; i++)
               integ_reg[i] <= integ_next[i];
            bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + 1'b1;
         end
         // The frame-end strobe lags the last capture by one cycle, so the
         // combs see integrators that already hold that last bit.
         dec_stb_reg <= cap_stb && (bit_cnt_reg == LAST_BIT);

         if (dec_stb_reg) begin
            for (int i = 0; i < CIC_ORDER; i++)
               dly_reg[i] <= comb_in[i];
            // The first frames are discarded while the comb delays fill.
            if (warm_cnt_reg != WARM_FRAMES)
               warm_cnt_reg <= warm_cnt_reg + 1'b1;
         end

         overrun_reg <= 1'b0;
         if (load) begin
            // A simultaneous accept consumes the old sample, so overrun is
            // only raised when the old sample goes unread.
            sample_reg  <= sat_val;
            valid_reg   <= 1'b1;
            overrun_reg <= valid_reg && !sample_ready;
         end else if (valid_reg && sample_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign sample_out   = sample_reg;
   assign sample_valid = valid_reg;
   assign overrun      = overrun_reg;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
`timescale 1ns/1ps
module tb_pdm_cic_decimator;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               enable = 1'b0;
   logic               pdm_data = 1'b0;
   logic               sample_ready = 1'b0;
   logic               pdm_clk;
   logic signed [15:0] sample_out;
   logic               sample_valid;
   logic               overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int pat_mode = 0;   // 0 zeros, 1 ones, 2 alternating, 3 three ones : one zero
   int pat_idx  = 0;

   // Bits per frame (71 clk each) times 32 bits gives the frame period.
   // The first valid sample comes 3 warm-up frames plus 2273 cycles after
   // enable.
   localparam int FRAME     = 2272;
   localparam int FIRST_VAL = 3 * 2272 + 2273;

   pdm_cic_decimator dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .pdm_clk      (pdm_clk),
      .pdm_data     (pdm_data),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   initial forever #5 clk = ~clk;

   // Microphone model: it drives a new bit shortly after each pdm_clk fall.
   initial begin
      forever begin
         @(negedge pdm_clk);
         #2;
         case (pat_mode)
            0:       pdm_data = 1'b0;
            1:       pdm_data = 1'b1;
            2:       pdm_data = pat_idx[0];
            default: pdm_data = (pat_idx[1:0] != 2'd3);
         endcase
         pat_idx++;
      end
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic wait_valid(input int max_cyc, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!sample_valid && cyc < max_cyc);
      if (sample_valid)
         $display("sample %0d after %0d cycles", sample_out, cyc);
      else
         $display("no sample within %0d cycles", cyc);
   endtask

   task automatic restart(input int mode);
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      pat_mode = mode;
      enable = 1'b1;
   endtask

   task automatic test_reset;
      #23;
      n_checks++; if (pdm_clk !== 1'b0) $display("FAIL reset_pdm_clk: got %b expected 0", pdm_clk); else n_pass++;
      n_checks++; if (sample_out !== 16'sd0) $display("FAIL reset_sample: got %0d expected 0", sample_out); else n_pass++;
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sample_valid); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (pdm_clk !== 1'b0) $display("FAIL idle_pdm_clk: got %b expected 0", pdm_clk); else n_pass++;
   endtask

   task automatic test_pdm_clk;
      int cnt, lo1, hi, lo2;
      enable = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (pdm_clk !== 1'b1 && cnt < 200);
      n_checks++; if (cnt != 1) $display("FAIL pdm_clk_first_rise: got %0d expected 1", cnt); else n_pass++;
      cnt = 0;
      while (pdm_clk === 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
      lo1 = 0;
      while (pdm_clk === 1'b0 && lo1 < 200) begin @(negedge clk); lo1++; end
      hi = 0;
      while (pdm_clk === 1'b1 && hi < 200) begin @(negedge clk); hi++; end
      lo2 = 0;
      while (pdm_clk === 1'b0 && lo2 < 200) begin @(negedge clk); lo2++; end
      $display("pdm_clk low %0d high %0d low %0d", lo1, hi, lo2);
      n_checks++; if (lo1 != 36) $display("FAIL pdm_clk_low: got %0d expected 36", lo1); else n_pass++;
      n_checks++; if (hi != 35) $display("FAIL pdm_clk_high: got %0d expected 35", hi); else n_pass++;
      n_checks++; if (hi + lo2 != 71) $display("FAIL pdm_clk_period: got %0d expected 71", hi + lo2); else n_pass++;
   endtask

   task automatic test_all_ones;
      int cyc;
      sample_ready = 1'b1;
      restart(1);
      wait_valid(FIRST_VAL + 100, cyc);
      n_checks++; if (cyc != FIRST_VAL) $display("FAIL ones_first_latency: got %0d expected %0d", cyc, FIRST_VAL); else n_pass++;
      n_checks++; if (sample_out !== 16'sd32767) $display("FAIL ones_value: got %0d expected 32767", sample_out); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL ones_overrun: got %b expected 0", overrun); else n_pass++;
      @(negedge clk);
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL ones_valid_drop: got %b expected 0", sample_valid); else n_pass++;
      wait_valid(FRAME + 100, cyc);
      n_checks++; if (cyc != FRAME - 1) $display("FAIL ones_period: got %0d expected %0d", cyc + 1, FRAME); else n_pass++;
      n_checks++; if (sample_out !== 16'sd32767) $display("FAIL ones_value2: got %0d expected 32767", sample_out); else n_pass++;
   endtask

   task automatic test_patterns;
      int modes [3] = '{2, 3, 0};
      logic signed [15:0] expv [3] = '{16'sd0, 16'sd16384, -16'sd32768};
      int cyc;
      for (int k = 0; k < 3; k++) begin
         restart(modes[k]);
         wait_valid(FIRST_VAL + 100, cyc);
         n_checks++;
         if (!sample_valid || sample_out !== expv[k])
            $display("FAIL pattern_%0d: got %0d (valid %b) expected %0d", modes[k], sample_out, sample_valid, expv[k]);
         else
            n_pass++;
      end
   endtask

   // Zeros are steady and the last sample was just seen with ready high.
   // Ones start exactly at the next frame boundary, so the next three samples
   // cover 1, 2 and 3 frames of ones. That gives
   // 2*C(34,3)-32768 = -20800, then 32768-2*C(32,3) = 22848, then saturation.
   task automatic test_handshake;
      int  cyc;
      bit  dropped;
      pat_mode = 1;
      @(negedge clk);
      sample_ready = 1'b0;
      wait_valid(FRAME + 100, cyc);
      n_checks++; if (cyc != FRAME - 1) $display("FAIL hs_first_timing: got %0d expected %0d", cyc, FRAME - 1); else n_pass++;
      n_checks++; if (sample_out !== -16'sd20800) $display("FAIL hs_step1: got %0d expected -20800", sample_out); else n_pass++;
      cyc = 0;
      dropped = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (!sample_valid) dropped = 1'b1;
      end while (overrun !== 1'b1 && cyc < FRAME + 100);
      n_checks++; if (cyc != FRAME) $display("FAIL hs_overrun_time: got %0d expected %0d", cyc, FRAME); else n_pass++;
      n_checks++; if (dropped) $display("FAIL hs_valid_held: got dropped expected held"); else n_pass++;
      n_checks++; if (sample_out !== 16'sd22848) $display("FAIL hs_overwrite: got %0d expected 22848", sample_out); else n_pass++;
      @(negedge clk);
      n_checks++; if (overrun !== 1'b0) $display("FAIL hs_overrun_pulse: got %b expected 0", overrun); else n_pass++;
      repeat (FRAME - 2) @(negedge clk);
      sample_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (sample_valid !== 1'b1 || sample_out !== 16'sd32767 || overrun !== 1'b0)
         $display("FAIL hs_coincident: got valid %b value %0d overrun %b expected 1 32767 0", sample_valid, sample_out, overrun);
      else
         n_pass++;
      @(negedge clk);
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL hs_accept_drop: got %b expected 0", sample_valid); else n_pass++;
   endtask

   task automatic test_enable_drop;
      int cyc;
      sample_ready = 1'b0;
      wait_valid(FRAME + 100, cyc);
      repeat (500) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pdm_clk !== 1'b0 || sample_valid !== 1'b0 || sample_out !== 16'sd0)
         $display("FAIL en_drop: got pdm_clk %b valid %b value %0d expected 0 0 0", pdm_clk, sample_valid, sample_out);
      else
         n_pass++;
      sample_ready = 1'b1;
      enable = 1'b1;
      wait_valid(FIRST_VAL + 100, cyc);
      n_checks++; if (cyc != FIRST_VAL) $display("FAIL en_rewarm: got %0d expected %0d", cyc, FIRST_VAL); else n_pass++;
      n_checks++; if (sample_out !== 16'sd32767) $display("FAIL en_value: got %0d expected 32767", sample_out); else n_pass++;
   endtask

   task automatic test_async_reset;
      int cyc;
      sample_ready = 1'b0;
      wait_valid(FRAME + 100, cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (pdm_clk !== 1'b1 && cyc < 200);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (pdm_clk !== 1'b0 || sample_valid !== 1'b0 || sample_out !== 16'sd0 || overrun !== 1'b0)
         $display("FAIL async_reset: got pdm_clk %b valid %b value %0d overrun %b expected all 0", pdm_clk, sample_valid, sample_out, overrun);
      else
         n_pass++;
      @(negedge clk);
      rst = 1'b1;
      sample_ready = 1'b1;
      wait_valid(FIRST_VAL + 100, cyc);
      n_checks++; if (cyc != FIRST_VAL) $display("FAIL reset_rewarm: got %0d expected %0d", cyc, FIRST_VAL); else n_pass++;
      n_checks++; if (sample_out !== 16'sd32767) $display("FAIL reset_value: got %0d expected 32767", sample_out); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_pdm_clk;
      test_all_ones;
      test_patterns;
      test_handshake;
      test_enable_drop;
      test_async_reset;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
